// File: rtl/weight_fill_pkg.sv
// rtl/weight_fill_pkg.sv - shared types and constants for the weight FIFO fill controller
package weight_fill_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } fill_state_t;

    typedef struct packed {
        logic rd;
        logic first;
        logic last_tile;
        logic last_cmd;
    } pipe_entry_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/fill_lat_pipe.sv
// rtl/fill_lat_pipe.sv - read-latency shift register carrying write strobe and tile/command markers
module fill_lat_pipe
    import weight_fill_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  pipe_entry_t din,
    output pipe_entry_t dout,
    output logic        drained
);

    pipe_entry_t stage [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

    // Only the output stage still holds a read, so the pipe is empty after this edge.
    always_comb begin
        drained = 1'b1;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (stage[i].rd) drained = 1'b0;
        end
    end

endmodule

// File: rtl/weight_fifo_fill_ctrl.sv
// rtl/weight_fifo_fill_ctrl.sv - multi-tile weight-memory read issue and FIFO write alignment
// Optional stall counter output enabled by FILL_STALL_CNT_EN.
module weight_fifo_fill_ctrl
    import weight_fill_pkg::*;
#(
    parameter int SYS_ARR_ROWS = 16,
    parameter int SYS_ARR_COLS = 16,
    parameter int ADDR_WIDTH   = 8,
    parameter int RD_LAT       = 1,
    parameter int MAX_TILES    = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               abort,
    input  logic [$clog2(SYS_ARR_ROWS)-1:0]    num_row,
    input  logic [$clog2(SYS_ARR_COLS)-1:0]    num_col,
    input  logic [$clog2(MAX_TILES)-1:0]       num_tiles,
    input  logic [ADDR_WIDTH-1:0]              base_addr,
    input  logic [ADDR_WIDTH-1:0]              tile_stride,
    input  logic                               fifo_full,
    output logic [SYS_ARR_COLS-1:0]            weightMem_rd_en,
    output logic [SYS_ARR_COLS*ADDR_WIDTH-1:0] weightMem_rd_addr,
    output logic [SYS_ARR_COLS-1:0]            fifo_wr_en,
    output logic                               fifo_active,
    output logic                               tile_done,
    output logic                               busy,
    output logic                               done,
    output logic                               done_pulse
`ifdef FILL_STALL_CNT_EN
    ,
    output logic [15:0]                        stall_cycles
`endif
);

    localparam int RW  = $clog2(SYS_ARR_ROWS);
    localparam int CW  = $clog2(SYS_ARR_COLS);
    localparam int TW  = $clog2(MAX_TILES);
    localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                         (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

    fill_state_t             state, state_nxt;
    logic [RW-1:0]           num_row_q, word_idx;
    logic [CW-1:0]           num_col_q;
    logic [TW-1:0]           num_tiles_q, tile_idx;
    logic [ADDR_WIDTH-1:0]   stride_q, tile_addr, addr;
    logic [SYS_ARR_COLS-1:0] col_mask;
    logic                    accept, issue, last_word, last_tile, drained;
    pipe_entry_t             pipe_in, pipe_out;

    assign accept    = (state == IDLE) && start && !abort;
    assign issue     = (state == ISSUE) && !fifo_full && !abort;
    assign last_word = (word_idx == num_row_q);
    assign last_tile = (tile_idx == num_tiles_q);
    // tile_addr accumulates the stride, so no multiplier is needed; wraps modulo 2^ADDR_WIDTH.
    assign addr      = tile_addr + ADDR_WIDTH'(word_idx);

    always_comb begin
        col_mask = '0;
        for (int i = 0; i < SYS_ARR_COLS; i++) col_mask[i] = (i <= int'(num_col_q));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = ISSUE;
                ISSUE:   if (issue && last_word && last_tile) state_nxt = DRAIN;
                DRAIN:   if (drained) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            num_row_q   <= '0;
            num_col_q   <= '0;
            num_tiles_q <= '0;
            stride_q    <= '0;
            word_idx    <= '0;
            tile_idx    <= '0;
            tile_addr   <= '0;
        end else if (accept) begin
            num_row_q   <= num_row;
            num_col_q   <= num_col;
            num_tiles_q <= num_tiles;
            stride_q    <= tile_stride;
            word_idx    <= '0;
            tile_idx    <= '0;
            tile_addr   <= base_addr;
        end else if (issue) begin
            if (last_word) begin
                word_idx <= '0;
                if (!last_tile) begin
                    tile_idx  <= tile_idx + TW'(1);
                    tile_addr <= tile_addr + stride_q;
                end
            end else begin
                word_idx <= word_idx + RW'(1);
            end
        end
    end

    always_comb begin
        pipe_in           = '0;
        pipe_in.rd        = issue;
        pipe_in.first     = issue && (word_idx == '0);
        pipe_in.last_tile = issue && last_word;
        pipe_in.last_cmd  = issue && last_word && last_tile;
    end

    fill_lat_pipe #(.DEPTH(LAT)) u_pipe (
        .clk     (clk),
        .reset   (reset),
        .flush   (abort),
        .din     (pipe_in),
        .dout    (pipe_out),
        .drained (drained)
    );

    // The abort cycle itself also suppresses the pipe output, not just the following ones.
    assign weightMem_rd_en   = issue ? col_mask : '0;
    assign weightMem_rd_addr = {SYS_ARR_COLS{addr}};
    assign fifo_wr_en        = (pipe_out.rd && !abort) ? col_mask : '0;
    assign fifo_active       = pipe_out.first && !abort;
    assign tile_done         = pipe_out.last_tile && !abort;
    assign done_pulse        = pipe_out.last_cmd && !abort;
    assign busy              = (state != IDLE);
    assign done              = !busy;

`ifdef FILL_STALL_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
        end else if (accept) begin
            stall_cycles <= '0;
        end else if ((state == ISSUE) && fifo_full && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule
